dcache_miss_ctrl: RTL

- Load-side controller directly upstream of the 128x64 data-cache memory array.
- Receives load requests from the LSQ and probes the array through its rd1 port.
- Tracks misses in a small MSHR file, issues BUS_LOAD requests to Dmem and matches returning Dmem_tag values.
- Drives the array's wr0 fill port and returns completed loads to the LSQ.

---
 rtl/dcache_miss_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dcache_miss_ctrl.sv
// Load-side miss controller: probes the data array, tracks misses in an MSHR file, fills from Dmem.
// Latency: hit completes 1 cycle after acceptance; a miss completes 1 cycle after its Dmem_tag fill.
// Backpressure: ld_stall on fill cycles or when no entry is free; DCACHE_HIT_UNDER_MISS_EN lifts the stall-while-busy rule.
module dcache_miss_ctrl #(
  parameter int MSHR_DEPTH = 4,
  parameter int ID_W       = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ld_en,
  input  logic [63:0]     ld_addr,
  input  logic [ID_W-1:0] ld_id,
  output logic            ld_stall,
  output logic [6:0]      rd1_idx,
  output logic [21:0]     rd1_tag,
  input  logic            rd1_valid,
  input  logic [63:0]     rd1_data,
  output logic [1:0]      Dmem_command,
  output logic [63:0]     Dmem_addr,
  input  logic [3:0]      Dmem_response,
  input  logic [3:0]      Dmem_tag,
  input  logic [63:0]     Dmem_data,
  output logic            wr0_en,
  output logic [6:0]      wr0_idx,
  output logic [21:0]     wr0_tag,
  output logic [63:0]     wr0_data,
  output logic            ld_done,
  output logic [ID_W-1:0] ld_done_id,
  output logic [63:0]     ld_done_data,
  output logic            mshr_busy
);

  localparam int IW = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;

  typedef enum logic [1:0] {FREE, WAIT_ISSUE, WAIT_DATA} mshr_state_e;

  mshr_state_e     st     [MSHR_DEPTH];
  logic [28:0]     e_addr [MSHR_DEPTH];
  logic [ID_W-1:0] e_id   [MSHR_DEPTH];
  logic [3:0]      e_tag  [MSHR_DEPTH];

  logic          fill_vld, iss_vld, free_vld;
  logic [IW-1:0] fill_sel, iss_sel, free_sel;
  logic          blocking_stall, accept, alloc, hit, busy_nxt;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^{ld_addr[63:32], ld_addr[2:0]};

`ifdef DCACHE_HIT_UNDER_MISS_EN
  assign blocking_stall = 1'b0;
`else
  assign blocking_stall = mshr_busy;
`endif

  // Descending scans so the lowest matching index wins.
  always_comb begin
    fill_vld = 1'b0;
    fill_sel = '0;
    iss_vld  = 1'b0;
    iss_sel  = '0;
    free_vld = 1'b0;
    free_sel = '0;
    for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
      if (st[i] == WAIT_DATA && Dmem_tag != 4'd0 && e_tag[i] == Dmem_tag) begin
        fill_vld = 1'b1;
        fill_sel = IW'(i);
      end
      if (st[i] == WAIT_ISSUE) begin
        iss_vld = 1'b1;
        iss_sel = IW'(i);
      end
      if (st[i] == FREE) begin
        free_vld = 1'b1;
        free_sel = IW'(i);
      end
    end
  end

  assign ld_stall = ld_en & (fill_vld | (~rd1_valid & ~free_vld) | blocking_stall);
  assign accept   = ld_en & ~ld_stall;
  assign alloc    = accept & ~rd1_valid;
  assign hit      = accept & rd1_valid;

  assign rd1_idx = ld_addr[9:3];
  assign rd1_tag = ld_addr[31:10];

  assign Dmem_command = iss_vld ? 2'd1 : 2'd0;
  assign Dmem_addr    = iss_vld ? {32'b0, e_addr[iss_sel], 3'b0} : 64'd0;

  assign wr0_en   = fill_vld;
  assign wr0_idx  = e_addr[fill_sel][6:0];
  assign wr0_tag  = e_addr[fill_sel][28:7];
  assign wr0_data = Dmem_data;

  // Occupancy after this edge, so mshr_busy tracks the entry states it is registered with.
  always_comb begin
    busy_nxt = 1'b0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if ((st[i] != FREE && !(fill_vld && fill_sel == IW'(i))) ||
          (alloc && free_sel == IW'(i)))
        busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        st[i]     <= FREE;
        e_addr[i] <= '0;
        e_id[i]   <= '0;
        e_tag[i]  <= '0;
      end
      ld_done      <= 1'b0;
      ld_done_id   <= '0;
      ld_done_data <= '0;
      mshr_busy    <= 1'b0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        case (st[i])
          FREE: begin
            if (alloc && free_sel == IW'(i)) begin
              st[i]     <= WAIT_ISSUE;
              e_addr[i] <= ld_addr[31:3];
              e_id[i]   <= ld_id;
            end
          end
          WAIT_ISSUE: begin
            if (iss_sel == IW'(i) && Dmem_response != 4'd0) begin
              st[i]    <= WAIT_DATA;
              e_tag[i] <= Dmem_response;
            end
          end
          WAIT_DATA: begin
            if (fill_vld && fill_sel == IW'(i))
              st[i] <= FREE;
          end
          default: st[i] <= FREE;
        endcase
      end
      ld_done   <= fill_vld | hit;
      mshr_busy <= busy_nxt;
      if (fill_vld) begin
        ld_done_id   <= e_id[fill_sel];
        ld_done_data <= Dmem_data;
      end else if (hit) begin
        ld_done_id   <= ld_id;
        ld_done_data <= rd1_data;
      end
    end
  end

endmodule
